dmem_responder: RTL and testbench

Multi-cycle data-memory responder for the CPU load/store bus. It accepts one request at a time over a valid/ready handshake and services it after a programmable latency. It returns read data or write completion over a second valid/ready handshake. It replaces the zero-latency data memory when the CPU runs with a stalling memory interface, and owns its own word-addressed storage array.

---
 rtl/dmem_responder.sv | 147 ++++++++++++++
 tb/tb_dmem_responder.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Purpose: word-addressed data memory behind a request/response handshake, one transaction at a time.
// Latency: response valid LATENCY cycles after the accepting edge; stores and loads resolve on that edge.
// Backpressure: req_ready drops from acceptance to completion; the response holds while resp_ready is low.
module dmem_responder #(
    parameter int WORD    = 32,
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [WORD-1:0]     req_addr,
    input  logic [WORD-1:0]     req_wdata,
    input  logic [WORD/8-1:0]   req_be,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [WORD-1:0]     resp_rdata,
    output logic                resp_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int NB = WORD / 8;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [3:0]        cnt;
    logic [3:0]        cnt_nxt;

    // Request fields captured at acceptance; the requester may change them afterwards.
    logic              lat_write;
    logic [WORD-1:0]   lat_addr;
    logic [WORD-1:0]   lat_wdata;
    logic [NB-1:0]     lat_be;

    logic [WORD-1:0]   mem [DEPTH];

    logic              accept;
    logic              enter_resp;
    logic [AW-1:0]     widx;
    logic              misaligned;
    logic              out_of_range;
    logic              addr_err;

    assign accept       = req_valid && req_ready;
    // The WAIT cycle in which the counter sits at zero is the one whose closing edge resolves the access.
    assign enter_resp   = (state == WAIT) && (cnt == 4'd0);
    assign widx         = lat_addr[AW+1:2];
    assign misaligned   = |lat_addr[1:0];
    assign out_of_range = |lat_addr[WORD-1:AW+2];
    assign addr_err     = misaligned || out_of_range;

    // State and latency counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state decode and handshake outputs.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_nxt = WAIT;
                    cnt_nxt   = CNT_INIT;
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    state_nxt = RESP;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

    // Capture the request at the accepting edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_write <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_be    <= '0;
        end else if (accept) begin
            lat_write <= req_write;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            lat_be    <= req_be;
        end
    end

    // Response registers: loaded once on entry to RESP, held until the next transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else if (enter_resp) begin
            resp_err <= addr_err;
            if (addr_err || lat_write) begin
                resp_rdata <= '0;
            end else begin
                resp_rdata <= mem[widx];
            end
        end
    end

    // Byte-masked store commit; contents deliberately carry no reset.
    always_ff @(posedge clk) begin
        if (enter_resp && lat_write && !addr_err) begin
            for (int b = 0; b < NB; b++) begin
                if (lat_be[b]) begin
                    mem[widx][8*b +: 8] <= lat_wdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

    logic        clk;
    logic        rst_n;
    logic [2:0]  req_valid;
    logic [2:0]  req_ready;
    logic [2:0]  req_write;
    logic [31:0] req_addr  [3];
    logic [31:0] req_wdata [3];
    logic [3:0]  req_be    [3];
    logic [2:0]  resp_valid;
    logic [2:0]  resp_ready;
    logic [31:0] resp_rdata [3];
    logic [2:0]  resp_err;

    int checks = 0;
    int errors = 0;

    // Instance 0: LATENCY 2, instance 1: LATENCY 1, instance 2: LATENCY 4.
    for (genvar g = 0; g < 3; g++) begin : g_dut
        dmem_responder #(
            .WORD(32), .DEPTH(1024),
            .LATENCY(g == 0 ? 2 : (g == 1 ? 1 : 4))
        ) u_dut (
            .clk(clk), .rst_n(rst_n),
            .req_valid(req_valid[g]), .req_ready(req_ready[g]),
            .req_write(req_write[g]), .req_addr(req_addr[g]),
            .req_wdata(req_wdata[g]), .req_be(req_be[g]),
            .resp_valid(resp_valid[g]), .resp_ready(resp_ready[g]),
            .resp_rdata(resp_rdata[g]), .resp_err(resp_err[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          inst;
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  be;
        logic [31:0] er;
        logic        ee;
        int          stall;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    // Scoreboard: pop and compare at each completing response.
    always @(negedge clk) begin
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            if (rst_n && resp_valid[i] && resp_ready[i]) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp inst %0d: got a response, required none", i);
                end else begin
                    e = sbq.pop_front();
                    chk("resp_inst", i, e.inst);
                    chk("resp_rdata", resp_rdata[i], e.rdata);
                    chk("resp_err", {31'd0, resp_err[i]}, {31'd0, e.err});
                end
            end
        end
    end

    // One full transaction on instance i; returns at a falling edge.
    task automatic txn(input int i, input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] be, input logic [31:0] er, input logic ee,
                       input int stall, input int exp_lat);
        int n;
        logic busy_ok;
        logic hold_ok;
        logic [31:0] cap_d;
        logic cap_e;
        exp_t e;
        req_write[i] = w;
        req_addr[i]  = a;
        req_wdata[i] = d;
        req_be[i]    = be;
        req_valid[i] = 1'b1;
        resp_ready[i] = (stall == 0);
        n = 0;
        while (!req_ready[i] && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready[i]) begin
            chk("accept_timeout", 32'd0, 32'd1);
            req_valid[i] = 1'b0;
            return;
        end
        @(posedge clk);
        e.inst = i; e.rdata = er; e.err = ee;
        sbq.push_back(e);
        #1;
        req_valid[i] = 1'b0;
        req_write[i] = 1'($urandom);
        req_addr[i]  = $urandom;
        req_wdata[i] = $urandom;
        req_be[i]    = 4'($urandom);
        busy_ok = 1'b1;
        n = 0;
        @(negedge clk);
        while (!resp_valid[i] && n < 20) begin
            if (req_ready[i]) busy_ok = 1'b0;
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        chk("resp_latency", n, exp_lat);
        if (!resp_valid[i]) return;
        if (req_ready[i]) busy_ok = 1'b0;
        chk("busy_ready", {31'd0, busy_ok}, 32'd1);
        cap_d = resp_rdata[i];
        cap_e = resp_err[i];
        if (stall > 0) begin
            hold_ok = 1'b1;
            for (int s = 1; s <= stall; s++) begin
                @(posedge clk);
                #1;
                if (!resp_valid[i] || resp_rdata[i] !== cap_d || resp_err[i] !== cap_e || req_ready[i])
                    hold_ok = 1'b0;
                if (s == stall) resp_ready[i] = 1'b1;
            end
            chk("stall_hold", {31'd0, hold_ok}, 32'd1);
        end
        @(posedge clk);
        @(negedge clk);
        chk("done_valid", {31'd0, resp_valid[i]}, 32'd0);
        chk("done_ready", {31'd0, req_ready[i]}, 32'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t tbl[16];
        logic [31:0] d;
        logic quiet;
        int n;

        tbl[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0, 0};
        tbl[1]  = '{1'b0, 32'h0000_0010, 32'hFFFF_FFFF, 4'h0, 32'hDEAD_BEEF, 1'b0, 3};
        tbl[2]  = '{1'b1, 32'h0000_0020, 32'hAABB_CCDD, 4'hF, 32'h0, 1'b0, 0};
        tbl[3]  = '{1'b1, 32'h0000_0020, 32'h1122_3344, 4'h3, 32'h0, 1'b0, 0};
        tbl[4]  = '{1'b0, 32'h0000_0020, 32'h0, 4'hF, 32'hAABB_3344, 1'b0, 1};
        tbl[5]  = '{1'b1, 32'h0000_0000, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0, 0};
        tbl[6]  = '{1'b0, 32'h0000_0013, 32'h0, 4'hF, 32'h0, 1'b1, 0};
        tbl[7]  = '{1'b1, 32'h0000_1000, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1, 2};
        tbl[8]  = '{1'b1, 32'h0000_0011, 32'h1234_5678, 4'hF, 32'h0, 1'b1, 0};
        tbl[9]  = '{1'b0, 32'h0000_0000, 32'h0, 4'hF, 32'hCAFE_F00D, 1'b0, 0};
        tbl[10] = '{1'b0, 32'h0000_0010, 32'h0, 4'hF, 32'hDEAD_BEEF, 1'b0, 0};
        tbl[11] = '{1'b1, 32'h0000_0024, 32'h0102_0304, 4'hF, 32'h0, 1'b0, 0};
        tbl[12] = '{1'b1, 32'h0000_0024, 32'h9999_9999, 4'h0, 32'h0, 1'b0, 0};
        tbl[13] = '{1'b1, 32'h0000_0024, 32'hA5A5_0000, 4'hC, 32'h0, 1'b0, 0};
        tbl[14] = '{1'b0, 32'h0000_0024, 32'h0, 4'h0, 32'hA5A5_0304, 1'b0, 0};
        tbl[15] = '{1'b0, 32'h8000_0000, 32'h0, 4'hF, 32'h0, 1'b1, 0};

        rst_n      = 1'b0;
        req_valid  = 3'b111;
        req_write  = 3'b111;
        resp_ready = 3'b000;
        for (int i = 0; i < 3; i++) begin
            req_addr[i] = 32'h10; req_wdata[i] = 32'h5555_5555; req_be[i] = 4'hF;
        end

        // Reset values, with req_valid held high to show it is ignored.
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("rst_resp_valid", {31'd0, resp_valid[i]}, 32'd0);
            chk("rst_resp_err", {31'd0, resp_err[i]}, 32'd0);
            chk("rst_resp_rdata", resp_rdata[i], 32'd0);
            chk("rst_req_ready", {31'd0, req_ready[i]}, 32'd1);
        end
        req_valid = 3'b000;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_valid", {29'd0, resp_valid}, 32'd0);

        // Table-driven functional sequence on the LATENCY=2 instance.
        for (int k = 0; k < 16; k++) begin
            txn(0, tbl[k].w, tbl[k].a, tbl[k].d, tbl[k].be, tbl[k].er, tbl[k].ee, tbl[k].stall, 2);
        end

        // Back-to-back store/load pairs, LATENCY=1, resp_ready held high.
        resp_ready[1] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            d = $urandom;
            txn(1, 1'b1, 32'(4 * k), d, 4'hF, 32'h0, 1'b0, 0, 1);
            txn(1, 1'b0, 32'(4 * k), 32'h0, 4'hF, d, 1'b0, 0, 1);
        end

        // Reset while a store is in WAIT: store must not commit.
        txn(2, 1'b1, 32'h40, 32'h0BAD_F00D, 4'hF, 32'h0, 1'b0, 0, 4);
        txn(2, 1'b1, 32'h44, 32'h0000_0077, 4'hF, 32'h0, 1'b0, 0, 4);
        req_write[2] = 1'b1; req_addr[2] = 32'h40; req_wdata[2] = 32'h1234_5678; req_be[2] = 4'hF;
        req_valid[2] = 1'b1; resp_ready[2] = 1'b1;
        @(posedge clk);
        #1;
        req_valid[2] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        chk("midrst_wait_valid", {31'd0, resp_valid[2]}, 32'd0);
        chk("midrst_wait_ready", {31'd0, req_ready[2]}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        quiet = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (resp_valid[2] || !req_ready[2]) quiet = 1'b0;
        end
        chk("midrst_wait_quiet", {31'd0, quiet}, 32'd1);
        txn(2, 1'b0, 32'h40, 32'h0, 4'hF, 32'h0BAD_F00D, 1'b0, 0, 4);

        // Reset while in RESP: store already committed, response dropped.
        req_write[2] = 1'b1; req_addr[2] = 32'h44; req_wdata[2] = 32'hFEED_FACE; req_be[2] = 4'hF;
        req_valid[2] = 1'b1; resp_ready[2] = 1'b0;
        @(posedge clk);
        #1;
        req_valid[2] = 1'b0;
        n = 0;
        while (!resp_valid[2] && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("midrst_resp_seen", {31'd0, resp_valid[2]}, 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        resp_ready[2] = 1'b1;
        quiet = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (resp_valid[2]) quiet = 1'b0;
        end
        chk("midrst_resp_quiet", {31'd0, quiet}, 32'd1);
        txn(2, 1'b0, 32'h44, 32'h0, 4'hF, 32'hFEED_FACE, 1'b0, 0, 4);

        chk("sb_empty", 32'(sbq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
